// File: rtl/emulador_de_teclado.sv
// 4x4 matrix-keypad emulator: closes one emulated key against the decoder's row strobes,
// with programmable hold time and contact bounce at press and release.
module emulador_de_teclado #(
    parameter int BOUNCE_CYCLES = 4,
    parameter int BOUNCE_PAIRS  = 3,
    parameter int LEN_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       key_code,
    input  logic             press_start,
    input  logic [LEN_W-1:0] press_len,
    input  logic [3:0]       lin_matriz,
    output logic [3:0]       col_matriz,
    output logic             busy,
    output logic             done
);

    localparam int PC_W = $clog2(BOUNCE_CYCLES) + 1;
    localparam int PI_W = $clog2(2 * BOUNCE_PAIRS) + 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(BOUNCE_CYCLES - 1);
    localparam logic [PI_W-1:0] PI_LAST = PI_W'((BOUNCE_PAIRS > 0) ? 2 * BOUNCE_PAIRS - 1 : 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BIN    = 3'd1;
    localparam logic [2:0] S_HOLD   = 3'd2;
    localparam logic [2:0] S_BOUT   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]       state;
    logic             contact;
    logic [1:0]       row_idx;
    logic [1:0]       col_idx;
    logic [LEN_W-1:0] len;
    logic [PC_W-1:0]  phase_cnt;
    logic [PI_W-1:0]  phase_idx;
    logic [LEN_W-1:0] hold_cnt;
    logic [1:0]       key_row;
    logic [1:0]       key_col;
    logic             start_ok;

    always_comb begin
        key_row = 2'd0;
        key_col = 2'd0;
        case (key_code)
            4'h1: begin key_row = 2'd0; key_col = 2'd0; end
            4'h2: begin key_row = 2'd0; key_col = 2'd1; end
            4'h3: begin key_row = 2'd0; key_col = 2'd2; end
            4'hA: begin key_row = 2'd0; key_col = 2'd3; end
            4'h4: begin key_row = 2'd1; key_col = 2'd0; end
            4'h5: begin key_row = 2'd1; key_col = 2'd1; end
            4'h6: begin key_row = 2'd1; key_col = 2'd2; end
            4'hB: begin key_row = 2'd1; key_col = 2'd3; end
            4'h7: begin key_row = 2'd2; key_col = 2'd0; end
            4'h8: begin key_row = 2'd2; key_col = 2'd1; end
            4'h9: begin key_row = 2'd2; key_col = 2'd2; end
            4'hC: begin key_row = 2'd2; key_col = 2'd3; end
            4'hF: begin key_row = 2'd3; key_col = 2'd0; end
            4'h0: begin key_row = 2'd3; key_col = 2'd1; end
            4'hE: begin key_row = 2'd3; key_col = 2'd2; end
            default: begin key_row = 2'd3; key_col = 2'd3; end
        endcase
    end

    // FINISH also accepts a new press so back-to-back presses lose only the done cycle.
    assign start_ok = press_start && ((state == S_IDLE) || (state == S_FINISH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            contact   <= 1'b0;
            row_idx   <= '0;
            col_idx   <= '0;
            len       <= '0;
            phase_cnt <= '0;
            phase_idx <= '0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                S_BIN, S_BOUT: begin
                    if (phase_cnt == PC_LAST) begin
                        phase_cnt <= '0;
                        if (phase_idx == PI_LAST) begin
                            phase_idx <= '0;
                            if (state == S_BIN) begin
                                state    <= S_HOLD;
                                contact  <= 1'b1;
                                hold_cnt <= LEN_W'(1);
                            end else begin
                                state   <= S_FINISH;
                                contact <= 1'b0;
                            end
                        end else begin
                            phase_idx <= phase_idx + 1'b1;
                            contact   <= ~contact;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == len) begin
                        hold_cnt  <= '0;
                        contact   <= 1'b0;
                        phase_cnt <= '0;
                        phase_idx <= '0;
                        state     <= (BOUNCE_PAIRS == 0) ? S_FINISH : S_BOUT;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    if (start_ok) begin
                        row_idx   <= key_row;
                        col_idx   <= key_col;
                        len       <= (press_len == '0) ? LEN_W'(1) : press_len;
                        contact   <= 1'b1;
                        phase_cnt <= '0;
                        phase_idx <= '0;
                        hold_cnt  <= LEN_W'(1);
                        state     <= (BOUNCE_PAIRS == 0) ? S_HOLD : S_BIN;
                    end else begin
                        contact <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        col_matriz = '1;
        if (contact && !lin_matriz[2'd3 - row_idx])
            col_matriz[col_idx] = 1'b0;
    end

    always_comb begin
        busy = (state == S_BIN) || (state == S_HOLD) || (state == S_BOUT);
        done = (state == S_FINISH);
    end

endmodule

// File: tb/tb_emulador_de_teclado.sv
// Directed bench for emulador_de_teclado: one instance without bounce, one with 3x4-cycle bounce.
module tb_emulador_de_teclado;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [3:0]  key0 = '0, lin0 = '1, col0;
    logic        ps0 = 1'b0, busy0, done0;
    logic [15:0] len0 = '0;

    logic [3:0]  key3 = '0, lin3 = '1, col3;
    logic        ps3 = 1'b0, busy3, done3;
    logic [15:0] len3 = '0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    localparam logic [1:0] EROW [16] = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                                        2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    localparam logic [1:0] ECOL [16] = '{2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0,
                                        2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd0};

    emulador_de_teclado #(.BOUNCE_CYCLES(4), .BOUNCE_PAIRS(0), .LEN_W(16)) dut0 (
        .clk(clk), .rst(rst), .key_code(key0), .press_start(ps0), .press_len(len0),
        .lin_matriz(lin0), .col_matriz(col0), .busy(busy0), .done(done0)
    );

    emulador_de_teclado #(.BOUNCE_CYCLES(4), .BOUNCE_PAIRS(3), .LEN_W(16)) dut3 (
        .clk(clk), .rst(rst), .key_code(key3), .press_start(ps3), .press_len(len3),
        .lin_matriz(lin3), .col_matriz(col3), .busy(busy3), .done(done3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done0(input int unsigned max_cycles);
        int unsigned n = 0;
        while (!done0 && n < max_cycles) begin
            tick();
            n++;
        end
        chk("done0_timeout", {7'd0, done0}, 8'h01);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_col;
        logic       c;

        // Reset state
        #2;
        chk("rst_col0", {4'h0, col0}, 8'h0F);
        chk("rst_busy0", {7'd0, busy0}, 8'h00);
        chk("rst_done0", {7'd0, done0}, 8'h00);
        chk("rst_col3", {4'h0, col3}, 8'h0F);
        chk("rst_busy3", {7'd0, busy3}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Map check: key 6 on row 1, 10 hold cycles; FINISH-edge press ignored, next edge accepted with len 0
        @(negedge clk);
        lin0 = 4'b1011; key0 = 4'h6; len0 = 16'd10; ps0 = 1'b1;
        tick();
        ps0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("map6_col", {4'h0, col0}, 8'h0B);
            chk("map6_busy", {7'd0, busy0}, 8'h01);
            if (i == 9) begin
                len0 = 16'd0;
                ps0  = 1'b1;
            end
            tick();
        end
        chk("map6_end_col", {4'h0, col0}, 8'h0F);
        chk("map6_done", {7'd0, done0}, 8'h01);
        chk("map6_end_busy", {7'd0, busy0}, 8'h00);
        tick();
        ps0 = 1'b0;
        chk("len0_col", {4'h0, col0}, 8'h0B);
        chk("len0_busy", {7'd0, busy0}, 8'h01);
        chk("len0_nodone", {7'd0, done0}, 8'h00);
        tick();
        chk("len0_end_col", {4'h0, col0}, 8'h0F);
        chk("len0_done", {7'd0, done0}, 8'h01);
        tick();
        chk("len0_idle_done", {7'd0, done0}, 8'h00);

        // Wrong row strobe: column never driven
        @(negedge clk);
        lin0 = 4'b0111; key0 = 4'h6; len0 = 16'd10; ps0 = 1'b1;
        tick();
        ps0 = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk("wrongrow_col", {4'h0, col0}, 8'h0F);
            tick();
        end
        chk("wrongrow_idle", {7'd0, busy0}, 8'h00);
        lin0 = 4'hF;

        // Full key map, combinational row sweep inside the first hold cycle
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            key0 = 4'(k); len0 = 16'd2; ps0 = 1'b1;
            tick();
            ps0 = 1'b0;
            for (int r = 0; r < 4; r++) begin
                lin0 = ~(4'b1000 >> r);
                #1;
                exp_col = (2'(r) == EROW[k]) ? ~(4'b0001 << ECOL[k]) : 4'hF;
                chk($sformatf("map_k%0h_r%0d", k, r), {4'h0, col0}, {4'h0, exp_col});
            end
            lin0 = 4'b0000;
            #1;
            chk($sformatf("map_k%0h_all", k), {4'h0, col0}, {4'h0, ~(4'b0001 << ECOL[k])});
            lin0 = 4'hF;
            wait_done0(10);
        end

        // Bounce shape with an ignored mid-HOLD press of another key
        @(negedge clk);
        lin3 = 4'b1011; key3 = 4'h6; len3 = 16'd20; ps3 = 1'b1;
        tick();
        ps3 = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (i < 24)       c = ((i / 4) % 2) == 0;
            else if (i < 44)  c = 1'b1;
            else if (i < 68)  c = (((i - 44) / 4) % 2) == 1;
            else              c = 1'b0;
            chk($sformatf("bnc_col_%0d", i), {4'h0, col3}, c ? 8'h0B : 8'h0F);
            chk($sformatf("bnc_busy_%0d", i), {7'd0, busy3}, (i < 68) ? 8'h01 : 8'h00);
            chk($sformatf("bnc_done_%0d", i), {7'd0, done3}, (i == 68) ? 8'h01 : 8'h00);
            if (i == 30) begin
                key3 = 4'h1; len3 = 16'd3; ps3 = 1'b1;
            end else begin
                ps3 = 1'b0;
            end
            if (i == 35) begin
                lin3 = 4'b0111;
                #1;
                chk("bnc_row0_col", {4'h0, col3}, 8'h0F);
                lin3 = 4'b1011;
            end
            tick();
        end

        // Asynchronous reset mid-HOLD
        @(negedge clk);
        lin0 = 4'b1011; key0 = 4'h6; len0 = 16'd10; ps0 = 1'b1;
        tick();
        ps0 = 1'b0;
        tick();
        tick();
        #2;
        chk("prerst_col", {4'h0, col0}, 8'h0B);
        rst = 1'b0;
        #1;
        chk("arst_col", {4'h0, col0}, 8'h0F);
        chk("arst_busy", {7'd0, busy0}, 8'h00);
        chk("arst_done", {7'd0, done0}, 8'h00);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("postrst_nodone", {7'd0, done0}, 8'h00);
            tick();
        end
        @(negedge clk);
        key0 = 4'hD; len0 = 16'd3; lin0 = 4'b1110; ps0 = 1'b1;
        tick();
        ps0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("postrst_col", {4'h0, col0}, 8'h07);
            tick();
        end
        chk("postrst_done", {7'd0, done0}, 8'h01);
        chk("postrst_end_col", {4'h0, col0}, 8'h0F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/emulador_de_teclado.md
# emulador_de_teclado

Synthesizable 4x4 matrix-keypad emulator: the key side of the row-scan/column-sense interface that `decodificador_de_teclado` drives. It watches the row strobes `lin_matriz` coming from the decoder and pulls the matching column line `col_matriz` low while an emulated key is closed. Press duration and contact bounce are programmable. Intended for self-checking loopback benches and board-level demos where no physical keypad is fitted.

## Interface
- `BOUNCE_CYCLES`, default 4: length in clk cycles of each bounce phase (open or closed); must be at least 1.
- `BOUNCE_PAIRS`, default 3: number of closed/open bounce pairs at press and at release; 0 disables bounce.
- `LEN_W`, default 16: width of `press_len`.
- `clk`  input  1: single clock, rising edge.
- `rst`  input  1: asynchronous, active-low reset.
- `key_code`  input  4: hex key to emulate; sampled on `press_start`.
- `press_start`  input  1: one-cycle request to start a press; honoured only when idle.
- `press_len`  input  LEN_W: stable-closed hold time in cycles; sampled on `press_start`; 0 is treated as 1.
- `lin_matriz`  input  4: row strobes from the decoder, active-low.
- `col_matriz`  output  4: column sense lines, active-low; idle value 4'b1111.
- `busy`  output  1: high while a press sequence is in progress.
- `done`  output  1: one-cycle pulse when a sequence completes.

## Operation
- Key map. Row r is closed when `lin_matriz[3-r]` is 0. Column c drives `col_matriz[c]` low.
  - Row 0: 1, 2, 3, A.
  - Row 1: 4, 5, 6, B.
  - Row 2: 7, 8, 9, C.
  - Row 3: F, 0, E, D.
  - Columns are listed c=0..3 in each row.
  - Example: key 6 is row 1, column 2. It is driven only when `lin_matriz[2]`=0, and then gives `col_matriz`=4'b1011.
- On `press_start`, the block latches `row_idx`, `col_idx` and `len`. `len` is `max(press_len,1)`.
- `col_matriz[c]` = ~(`contact` & (c==`col_idx`) & ~`lin_matriz[3-row_idx]`).
  - This path is combinational from `lin_matriz`, like a real switch: zero-cycle response to row changes.
  - `contact` is a registered internal bit.
  - Multiple low rows: the column is driven if the target row bit is low.
- FSM states:
  - IDLE: contact=0, busy=0.
  - BOUNCE_IN: 2·BOUNCE_PAIRS phases of BOUNCE_CYCLES each, alternating contact=1, 0, 1, 0, …; the first phase is closed.
  - HOLD: contact=1 for `len` cycles.
  - BOUNCE_OUT: 2·BOUNCE_PAIRS phases alternating contact=0, 1, …; the first phase is open and the last phase is closed.
  - FINISH: contact=0 for 1 cycle, `done`=1, then IDLE.
- Transitions:
  - IDLE→BOUNCE_IN on `press_start`.
  - BOUNCE_IN→HOLD after the last phase. If BOUNCE_PAIRS=0, IDLE goes directly to HOLD.
  - HOLD→BOUNCE_OUT when the hold counter reaches `len`. If BOUNCE_PAIRS=0, HOLD goes directly to FINISH.
  - BOUNCE_OUT→FINISH after the last phase.
- `press_start` while busy is ignored. Inputs latched at start are not disturbed.
- Counters:
  - Phase counter: width $clog2(BOUNCE_CYCLES)+1.
  - Phase index: width $clog2(2·BOUNCE_PAIRS)+1.
  - Hold counter: width LEN_W. Compare against `len`; no wrap past `len`.
- Reset (`rst`=0, any time, including mid-press):
  - State returns to IDLE.
  - contact, busy and done go to 0.
  - `col_matriz` returns to 4'b1111 immediately, because it is combinational from contact.
  - All latched values and counters clear to 0.

## Timing
- Reset values: `col_matriz`=4'b1111, `busy`=0, `done`=0.
- `press_start` is sampled at rising edge k. From edge k onward, `busy`=1 and contact=1 (the first closed phase, or HOLD).
- Let B = 2·BOUNCE_PAIRS·BOUNCE_CYCLES. Contact sequence:
  - Bounce-in occupies cycles k..k+B-1.
  - Stable closed occupies cycles k+B..k+B+len-1.
  - Bounce-out occupies cycles k+B+len..k+2B+len-1.
- FINISH is the cycle starting at edge k+2B+len:
  - `done`=1, `busy`=0, contact=0.
  - A `press_start` sampled at that edge is ignored.
  - The next press is accepted one edge later.
- `col_matriz` follows `lin_matriz` with no register delay.

## Test plan
- Loopback with `decodificador_de_teclado` at DEBOUNCE_P=100, BOUNCE_PAIRS=0:
  - For each of the 16 keys, wait for the matching row strobe, then issue `press_start` with `press_len`=101.
  - Required: `tecla_valid` rises with `tecla_value`=key within 110 cycles, for every key.
- Standalone map check: force `lin_matriz`=4'b1011, press key 6 with `press_len`=10, BOUNCE_PAIRS=0.
  - Required: `col_matriz`=4'b1011 for exactly 10 cycles, then 4'b1111.
  - With `lin_matriz`=4'b0111, `col_matriz` stays 4'b1111 throughout.
- Bounce shape, with BOUNCE_PAIRS=3, BOUNCE_CYCLES=4, `press_len`=20, row strobe held active. Required:
  - 3 low/high 4-cycle pairs, then 20 cycles low.
  - Then a 3-pair bounce-out that starts high and ends low.
  - `busy` high for exactly 68 cycles, then a single `done` pulse.
- Ignore while busy: a second `press_start` with a different key mid-HOLD leaves the waveform and latched key unchanged. Edge case: `press_len`=0 gives exactly 1 hold cycle.
- Reset mid-HOLD: assert `rst`=0 asynchronously between edges.
  - Required: `col_matriz`=4'b1111 and `busy`=0 without waiting for a clock, and no `done` pulse.
  - A new press after release of reset completes normally.
